// File: rtl/jtframe_dwnld_bridge.sv
// jtframe_dwnld_bridge
// Turns the ioctl byte stream from the loader into 16-bit SDRAM programming
// writes. Each byte is mapped to one of four banks by download offset. An even
// byte followed by its odd partner in the same word is merged into one
// full-word write. Writes queue in a small FIFO, so ioctl bursts do not wait on
// SDRAM latency.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   downloading       loader active; ioctl_wr is ignored while low
//   ioctl_addr/dout   byte offset and data, qualified by the ioctl_wr strobe
//   prog_addr/data    word address inside prog_ba, 16-bit write data
//   prog_mask         active-low byte enables (bit0 = data[7:0]), 2'b11 when idle
//   prog_we/prog_rdy  write request held until a one-cycle completion pulse
//   dwnld_busy        loader active or any write still outstanding
//   overflow          sticky: an entry was dropped because the FIFO was full

module jtframe_dwnld_bridge #(
  parameter int          SDRAMW    = 23,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter int          FIFOW     = 2,
  parameter bit          SWAB      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  // state | meaning
  // IDLE  | no write on the bus; pops the FIFO head when one is available
  // WR    | prog_we high, prog_* held stable until prog_rdy
  // GAP   | one dead cycle with prog_we low before the next write
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int DEPTH = 2**FIFOW;

  typedef struct packed {
    logic [1:0]        ba;
    logic [SDRAMW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
  } entry_t;

  localparam entry_t IDLE_OUT = '{ba: 2'd0, addr: '0, data: 16'd0, mask: 2'b11};

  // ---------------------------------------------------------------------------
  // Bank decode and byte lane
  // ---------------------------------------------------------------------------
  logic [1:0]        in_ba;
  logic [24:0]       in_off;
  logic [SDRAMW-1:0] in_waddr;
  logic              in_odd;
  entry_t            in_e;

  always_comb begin
    if (ioctl_addr >= BA3_START) begin
      in_ba  = 2'd3;
      in_off = ioctl_addr - BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      in_ba  = 2'd2;
      in_off = ioctl_addr - BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      in_ba  = 2'd1;
      in_off = ioctl_addr - BA1_START;
    end else begin
      in_ba  = 2'd0;
      in_off = ioctl_addr;
    end
    in_waddr  = SDRAMW'(in_off >> 1);
    in_odd    = in_off[0];
    in_e.ba   = in_ba;
    in_e.addr = in_waddr;
    in_e.data = {ioctl_dout, ioctl_dout};
    // Lane in data[15:8] is the odd byte normally, the even byte when swapped.
    in_e.mask = (in_odd ^ SWAB) ? 2'b01 : 2'b10;
  end

  // ---------------------------------------------------------------------------
  // Pending register: holds the last byte until we know whether it merges
  // ---------------------------------------------------------------------------
  entry_t pend_q, pend_d;
  logic   pend_v_q, pend_v_d;
  logic   pend_odd_q, pend_odd_d;
  logic   dl_q, dl_d;

  logic   accept, dl_fall, dl_rise, merge;
  logic   push;
  entry_t push_e;

  assign accept  = downloading & ioctl_wr;
  assign dl_fall = dl_q & ~downloading;
  assign dl_rise = ~dl_q & downloading;
  assign merge   = pend_v_q && !pend_odd_q && in_odd &&
                   (pend_q.ba == in_ba) && (pend_q.addr == in_waddr);

  always_comb begin
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    pend_odd_d = pend_odd_q;
    dl_d       = downloading;
    push       = 1'b0;
    push_e     = pend_q;
    if (accept) begin
      if (merge) begin
        push        = 1'b1;
        push_e.mask = 2'b00;
        // pend data holds the even byte on both halves
        push_e.data = SWAB ? {pend_q.data[7:0], ioctl_dout}
                           : {ioctl_dout, pend_q.data[7:0]};
        pend_v_d    = 1'b0;
      end else begin
        push       = pend_v_q;
        pend_d     = in_e;
        pend_v_d   = 1'b1;
        pend_odd_d = in_odd;
      end
    end else if (dl_fall && pend_v_q) begin
      push     = 1'b1;
      pend_v_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [FIFOW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFOW:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       st_q, st_d;
  logic             full, pop, push_ok;

  // cnt never exceeds DEPTH, so its top bit alone flags full
  assign full    = cnt_q[FIFOW];
  assign pop     = (st_q == S_IDLE) && (cnt_q != '0);
  assign push_ok = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_e;
      wr_ptr_d        = wr_ptr_q + FIFOW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFOW'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + (FIFOW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFOW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (dl_rise) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  entry_t out_q, out_d;
  logic   we_q, we_d;

  always_comb begin
    st_d  = st_q;
    out_d = out_q;
    we_d  = we_q;
    case (st_q)
      S_IDLE: begin
        if (pop) begin
          out_d = mem_q[rd_ptr_q];
          we_d  = 1'b1;
          st_d  = S_WR;
        end
      end
      S_WR: begin
        if (prog_rdy) begin
          we_d       = 1'b0;
          out_d.mask = 2'b11;
          st_d       = S_GAP;
        end
      end
      S_GAP:   st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      pend_odd_q <= 1'b0;
      dl_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      st_q       <= S_IDLE;
      out_q      <= IDLE_OUT;
      we_q       <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      pend_odd_q <= pend_odd_d;
      dl_q       <= dl_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      st_q       <= st_d;
      out_q      <= out_d;
      we_q       <= we_d;
    end
  end

  assign prog_addr  = out_q.addr;
  assign prog_data  = out_q.data;
  assign prog_mask  = out_q.mask;
  assign prog_ba    = out_q.ba;
  assign prog_we    = we_q;
  assign overflow   = ovf_q;
  assign dwnld_busy = downloading | pend_v_q | (cnt_q != '0) | (st_q != S_IDLE);

endmodule
